// File: rtl/uart_rx_mmio.sv
// Memory-mapped receive FIFO behind the UART receiver: RXDATA/STATUS/CTRL registers with overrun flag.
// Optional interrupt support (IE bit and irq output) is enabled by defining UART_RX_MMIO_IRQ_EN.
module uart_rx_mmio #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       bus_sel,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_rvalid,
  output logic       irq
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          ready_q;
  logic [7:0]    rdata_q, rdata_d;
  logic          rvalid_q;
  logic          ie_s;

  logic          push_s, push_ok_s, pop_s, overrun_s;
  logic          rd_acc_s, ctrl_wr_s, flush_s, ovr_clr_s;
  logic          ne_s, full_s;
  logic [31:0]   count_ext_s;
  logic [3:0]    count_sat_s;

  // Decode bus strobes and FIFO events for this cycle.
  always_comb begin
    rd_acc_s    = bus_sel & ~bus_we;
    ctrl_wr_s   = bus_sel & bus_we & (bus_addr == 2'd2);
    flush_s     = ctrl_wr_s & bus_wdata[2];
    ovr_clr_s   = ctrl_wr_s & bus_wdata[1];
    ne_s        = (count_q != {CW{1'b0}});
    full_s      = (count_q == CW'(DEPTH));
    count_ext_s = 32'(count_q);
    count_sat_s = (count_ext_s > 32'd15) ? 4'hF : count_ext_s[3:0];
    push_s      = rx_ready & ~ready_q;
    pop_s       = rd_acc_s & (bus_addr == 2'd0) & ne_s;
    // A pop in the same cycle frees the slot, so a push at full is not an overrun then.
    push_ok_s   = push_s & ~flush_s & (~full_s | pop_s);
    overrun_s   = push_s & ~flush_s & full_s & ~pop_s;
  end

  // Next-state for pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = overrun_s | (ovr_q & ~ovr_clr_s);
    if (flush_s) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Read data mux.
  always_comb begin
    case (bus_addr)
      2'd0:    rdata_d = ne_s ? mem_q[rd_ptr_q] : 8'h00;
      2'd1:    rdata_d = {count_sat_s, 1'b0, ovr_q, full_s, ne_s};
      2'd2:    rdata_d = {7'b0, ie_s};
      default: rdata_d = 8'h00;
    endcase
  end

  // FIFO state and bus response registers; ready_q tracks rx_ready during reset so a held level is not a new byte.
  always_ff @(posedge clk) begin
    ready_q <= rx_ready;
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovr_q    <= 1'b0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      rvalid_q <= rd_acc_s;
      if (rd_acc_s) begin
        rdata_q <= rdata_d;
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  // FIFO storage; contents are don't-care until counted.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

`ifdef UART_RX_MMIO_IRQ_EN
  logic ie_q, irq_q;

  // Interrupt enable and registered level interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        ie_q <= bus_wdata[0];
      end else begin
        ie_q <= ie_q;
      end
      irq_q <= ie_q & (ne_s | ovr_q);
    end
  end

  assign ie_s = ie_q;
  assign irq  = irq_q;
`else
  assign ie_s = 1'b0;
  assign irq  = 1'b0;
`endif

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
endmodule
